iterative_comparator: RTL and testbench

ITERATIVE_COMPARATOR -- requirements
Module: iterative_comparator

---
 rtl/comparator_pkg.sv | 44 ++++
 rtl/chunk_compare.sv | 24 ++
 rtl/iterative_comparator.sv | 147 ++++++++++++++
 tb/tb_iterative_comparator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the iterative comparator: operation encodings,
// FSM state type and the helper that maps latched flags to a result bit.
package comparator_pkg;

    typedef enum logic [2:0] {
        OP_EQ = 3'b000,
        OP_GE = 3'b001,
        OP_LE = 3'b010,
        OP_GT = 3'b011,
        OP_LT = 3'b100,
        OP_NE = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Encodings 110/111 are reserved; they scan normally and return 0.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= OP_NE;
    endfunction

    // Map the latched eq/gt/lt flags to the requested relation.
    function automatic logic op_result(input logic [2:0] op,
                                       input logic       eq,
                                       input logic       gt,
                                       input logic       lt);
        logic res;
        res = 1'b0;
        case (op)
            OP_EQ:   res = eq;
            OP_GE:   res = eq | gt;
            OP_LE:   res = eq | lt;
            OP_GT:   res = gt;
            OP_LT:   res = lt;
            OP_NE:   res = gt | lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational compare of one CHUNK-wide slice of both operands.
// When i_flip_msb is set the top bit of both slices is inverted, which turns
// an unsigned compare of the most significant slice into a two's-complement one.
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_flip_msb,
    output logic             o_eq,
    output logic             o_gt
);

    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;

    assign w_mask = CHUNK'(i_flip_msb) << (CHUNK - 1);
    assign w_a    = i_a ^ w_mask;
    assign w_b    = i_b ^ w_mask;
    assign o_eq   = (w_a == w_b);
    assign o_gt   = (w_a >  w_b);

endmodule

// File: rtl/iterative_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle,
// most significant chunk first, and stops at the first differing chunk.
// Optional feature macro: COMPARATOR_SIGNED_EN adds the in_signed port and
// two's-complement compare; without it every compare is unsigned.
module iterative_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             in_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [IDX_W-1:0] r_idx;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic             w_flip;
    logic             w_chunk_eq;
    logic             w_chunk_gt;
    logic             w_last;
    logic             w_stop;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_idx == '0);
    // Reserved ops never exit early, so they always take the full scan.
    assign w_stop    = !w_chunk_eq && (op_is_valid(r_op) || w_last);

`ifdef COMPARATOR_SIGNED_EN
    logic r_signed;
    assign w_flip = r_signed && (r_idx == IDX_TOP);
`else
    assign w_flip = 1'b0;
`endif

    chunk_compare #(
        .CHUNK      (CHUNK)
    ) u_chunk_compare (
        .i_a        (w_a_chunk),
        .i_b        (w_b_chunk),
        .i_flip_msb (w_flip),
        .o_eq       (w_chunk_eq),
        .o_gt       (w_chunk_gt)
    );

    // Request/scan/result handshake FSM with registered ready/valid.
    // NOTE: every register here is written with <= so all updates take effect
    // together at the edge and the read of r_idx sees the pre-edge value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_idx       <= '0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_op       <= in_op;
                        r_idx      <= IDX_TOP;
                        r_eq       <= 1'b0;
                        r_gt       <= 1'b0;
                        r_lt       <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_stop) begin
                        r_gt        <= w_chunk_gt;
                        r_lt        <= !w_chunk_gt;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_last) begin
                        r_eq        <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COMPARATOR_SIGNED_EN
    // Capture the signedness of the request alongside its operands.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_signed <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_signed <= in_signed;
        end
    end
`endif

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_valid & op_result(r_op, r_eq, r_gt, r_lt);

endmodule

// File: tb/tb_iterative_comparator.sv
// Self-checking bench for iterative_comparator (WIDTH=32, CHUNK=8).
// Table vectors plus random vectors checked against an independent model,
// with a scoreboard queue of expected result/latency per accepted request.
module tb_iterative_comparator;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
`ifdef COMPARATOR_SIGNED_EN
    logic        in_signed;
`endif
    logic        out_valid;
    logic        out_ready;
    logic        out_result;

    int n_total;
    int n_bad;

    logic sb_res[$];
    int   sb_lat[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        sgn;
        logic        exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    iterative_comparator #(
        .WIDTH      (32),
        .CHUNK      (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
`ifdef COMPARATOR_SIGNED_EN
        .in_signed  (in_signed),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: first differing byte from the top sets the latency.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, output logic res, output int lat);
        lat = 4;
        for (int i = 3; i >= 0; i--) begin
            if (a[i*8 +: 8] != b[i*8 +: 8]) begin
                lat = 4 - i;
                break;
            end
        end
        case (op)
            3'd0:    res = (a == b);
            3'd1:    res = (a >= b);
            3'd2:    res = (a <= b);
            3'd3:    res = (a >  b);
            3'd4:    res = (a <  b);
            3'd5:    res = (a != b);
            default: res = 1'b0;
        endcase
    endfunction

    // Issue one request, scramble inputs after accept, measure latency,
    // hold out_ready low for 'hold' cycles, then complete the handshake.
    task automatic run_req(input vec_t v, input int hold);
        int   n;
        logic exp_r;
        int   exp_l;
        @(negedge clock);
        check("ready_idle", 32'(in_ready), 32'd1);
        in_a  = v.a;
        in_b  = v.b;
        in_op = v.op;
`ifdef COMPARATOR_SIGNED_EN
        in_signed = v.sgn;
`endif
        in_valid = 1'b1;
        sb_res.push_back(v.exp_res);
        sb_lat.push_back(v.exp_lat);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_a  = $urandom;
        in_b  = $urandom;
        in_op = 3'($urandom_range(0, 7));
`ifdef COMPARATOR_SIGNED_EN
        in_signed = ~v.sgn;
`endif
        check("ready_busy", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
        exp_r = sb_res.pop_front();
        exp_l = sb_lat.pop_front();
        check("latency", 32'(n), 32'(exp_l));
        check("result", 32'(out_result), 32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(out_result), 32'(exp_r));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                input logic sgn, input logic r, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.sgn = sgn; v.exp_res = r; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
`ifdef COMPARATOR_SIGNED_EN
        in_signed = 1'b0;
`endif
        out_ready = 1'b0;

        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid_rel", 32'(out_valid), 32'd0);

        vecs.push_back(mk(32'h12345678, 32'h12345678, 3'd0, 1'b0, 1'b1, 4));
        vecs.push_back(mk(32'hFF000000, 32'h01FFFFFF, 3'd3, 1'b0, 1'b1, 1));
        vecs.push_back(mk(32'h00000005, 32'h00000007, 3'd4, 1'b0, 1'b1, 4));
        vecs.push_back(mk(32'h00000005, 32'h00000007, 3'd1, 1'b0, 1'b0, 4));
        vecs.push_back(mk(32'h00000005, 32'h00000007, 3'd2, 1'b0, 1'b1, 4));
        vecs.push_back(mk(32'h12345678, 32'h12345678, 3'd5, 1'b0, 1'b0, 4));
        vecs.push_back(mk(32'h12340000, 32'h12350000, 3'd5, 1'b0, 1'b1, 2));
        vecs.push_back(mk(32'h00AB0000, 32'h00AA0000, 3'd1, 1'b0, 1'b1, 2));
        vecs.push_back(mk(32'h0000FF00, 32'h00001000, 3'd2, 1'b0, 1'b0, 3));
        vecs.push_back(mk(32'h0000FF00, 32'h00001000, 3'd3, 1'b0, 1'b1, 3));
        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 3'd4, 1'b0, 1'b0, 1));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 3'd7, 1'b0, 1'b0, 4));
`ifdef COMPARATOR_SIGNED_EN
        vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 3'd4, 1'b1, 1'b1, 1));
        vecs.push_back(mk(32'h80000000, 32'h7FFFFFFF, 3'd3, 1'b1, 1'b0, 1));
        vecs.push_back(mk(32'hFFFFFF00, 32'hFFFFFF01, 3'd4, 1'b1, 1'b1, 4));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i], 0);
        end

        // Reserved op with a stalled consumer: result held at 0, no new accept.
        run_req(mk(32'hCAFEF00D, 32'hCAFEF00D, 3'd6, 1'b0, 1'b0, 4), 5);

        // Random unsigned vectors, sharing upper bytes to vary the exit point.
        for (int i = 0; i < 20; i++) begin
            vec_t v;
            logic r;
            int   lat;
            int   k;
            v.a  = $urandom;
            v.b  = v.a;
            k    = $urandom_range(0, 4);
            if (k < 4) v.b[k*8 +: 8] = 8'($urandom);
            v.op  = 3'($urandom_range(0, 5));
            v.sgn = 1'b0;
            model(v.a, v.b, v.op, r, lat);
            v.exp_res = r;
            v.exp_lat = lat;
            run_req(v, i % 3);
        end

        // Reset in the middle of a scan aborts the request.
        @(negedge clock);
        in_a = 32'h11223344; in_b = 32'h11223344; in_op = 3'd0; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(out_result), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_req(mk(32'h00000010, 32'h00000001, 3'd3, 1'b0, 1'b1, 4), 0);
        run_req(mk(32'h7F000000, 32'h80000000, 3'd4, 1'b0, 1'b1, 1), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
